// File: rtl/v_lsu_burst.sv
// v_lsu_burst: multi-beat vector load/store unit splitting one VLEN access into VLEN/VRAM_DW VRAM beats
module v_lsu_burst #(
  parameter int VLEN    = 512,
  parameter int VRAM_DW = 128,
  parameter int VRAM_AW = 64,
  parameter int VREG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [VRAM_AW-1:0]   req_base,
  input  logic [VRAM_AW-1:0]   req_stride,
  input  logic [VLEN-1:0]      req_wdata,
  input  logic [VLEN/8-1:0]    req_bmask,
  input  logic [VREG_AW-1:0]   req_vd,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_we,
  output logic [VREG_AW-1:0]   resp_vd,
  output logic [VLEN-1:0]      resp_rdata,
  output logic                 busy,
  output logic                 vram_r_ena,
  output logic [VRAM_AW-1:0]   vram_r_addr,
  input  logic [VRAM_DW-1:0]   vram_r_data,
  output logic                 vram_w_ena,
  output logic [VRAM_AW-1:0]   vram_w_addr,
  output logic [VRAM_DW-1:0]   vram_w_data,
  output logic [VRAM_DW-1:0]   vram_w_mask
);
  localparam int BEATS = VLEN / VRAM_DW;
  localparam int BW    = VRAM_DW / 8;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [VRAM_AW-1:0]              addr_q, addr_d, stride_q, stride_d;
  logic [BEATS-1:0][VRAM_DW-1:0]   wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [BEATS-1:0][BW-1:0]        bmask_q, bmask_d;
  logic [VREG_AW-1:0]              vd_q, vd_d;
  logic                            we_q, we_d;
  logic [BW-1:0]                   beat_bm;
  logic [VRAM_DW-1:0]              beat_wm;
  logic                            last;
  assign beat_bm = bmask_q[cnt_q];
  assign last    = cnt_q == CW'(BEATS - 1);
  for (genvar i = 0; i < BW; i++) begin : g_mask
    assign beat_wm[i*8 +: 8] = {8{beat_bm[i]}};
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    vd_d     = vd_q;
    we_d     = we_q;
    rbuf_d   = rbuf_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d   = req_base;
        stride_d = req_stride;
        wdata_d  = req_wdata;
        bmask_d  = req_bmask;
        vd_d     = req_vd;
        we_d     = req_we;
        rbuf_d   = '0;
        cnt_d    = '0;
        state_d  = req_we ? WR : RD;
      end
      RD, WR: begin
        if (state_q == RD) rbuf_d[cnt_q] = vram_r_data;
        addr_d = addr_q + stride_q;
        cnt_d  = cnt_q + 1'b1;
        if (last) state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      vd_q     <= '0;
      we_q     <= 1'b0;
      rbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      vd_q     <= vd_d;
      we_q     <= we_d;
      rbuf_q   <= rbuf_d;
    end
  end
  // req_ready is gated by rst so every output reads 0 while reset is held
  assign req_ready   = rst && state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign resp_valid  = state_q == RESP;
  assign resp_we     = we_q;
  assign resp_vd     = vd_q;
  assign resp_rdata  = rbuf_q;
  assign vram_r_ena  = state_q == RD;
  assign vram_r_addr = vram_r_ena ? addr_q : '0;
  assign vram_w_ena  = state_q == WR && |beat_bm;
  assign vram_w_addr = vram_w_ena ? addr_q : '0;
  assign vram_w_data = state_q == WR ? wdata_q[cnt_q] : '0;
  assign vram_w_mask = state_q == WR ? beat_wm : '0;
endmodule

// File: tb/tb_v_lsu_burst.sv
// tb_v_lsu_burst: directed and randomized checks of v_lsu_burst against an address/data reference model
module tb_v_lsu_burst;
  localparam int VLEN = 512, DW = 128, AW = 64, TW = 5;
  localparam int BEATS = VLEN / DW, BB = DW / 8;
  logic              clk = 1'b0, rst = 1'b0;
  logic              req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0]     req_base = '0, req_stride = '0;
  logic [VLEN-1:0]   req_wdata = '0;
  logic [VLEN/8-1:0] req_bmask = '0;
  logic [TW-1:0]     req_vd = '0;
  logic              req_ready, resp_valid, resp_we, busy, vram_r_ena, vram_w_ena;
  logic [TW-1:0]     resp_vd;
  logic [VLEN-1:0]   resp_rdata;
  logic [AW-1:0]     vram_r_addr, vram_w_addr;
  logic [DW-1:0]     vram_r_data, vram_w_data, vram_w_mask;
  int total = 0, bad = 0;

  v_lsu_burst dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_stride(req_stride), .req_wdata(req_wdata), .req_bmask(req_bmask),
    .req_vd(req_vd), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_vd(resp_vd), .resp_rdata(resp_rdata), .busy(busy), .vram_r_ena(vram_r_ena),
    .vram_r_addr(vram_r_addr), .vram_r_data(vram_r_data), .vram_w_ena(vram_w_ena),
    .vram_w_addr(vram_w_addr), .vram_w_data(vram_w_data), .vram_w_mask(vram_w_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return {a ^ 64'hDEAD_BEEF_0BAD_F00D, ~a + 64'h1234};
  endfunction

  assign vram_r_data = mem_rd(vram_r_addr);

  function automatic logic [DW-1:0] exp_mask(input logic [BB-1:0] b);
    logic [DW-1:0] m;
    for (int i = 0; i < DW; i++) m[i] = b[i/8];
    return m;
  endfunction

  function automatic logic [VLEN-1:0] rnd_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic xfer(input logic we, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                      input logic [VLEN-1:0] wd, input logic [VLEN/8-1:0] bm,
                      input logic [TW-1:0] vd, input int hold);
    logic [VLEN-1:0] exp_rd;
    logic [AW-1:0]   a;
    logic [BB-1:0]   b;
    exp_rd = '0;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_base = base; req_stride = stride;
    req_wdata = wd; req_bmask = bm; req_vd = vd;
    @(posedge clk); #1;
    // scramble request inputs so only the captured copy can be correct
    req_valid = 1'b0; req_we = ~we; req_base = ~base; req_stride = ~stride;
    req_wdata = ~wd; req_bmask = ~bm; req_vd = ~vd;
    for (int k = 0; k < BEATS; k++) begin
      a = base + stride * 64'(k);
      b = bm[k*BB +: BB];
      chk("beat_busy", busy, 1);
      chk("beat_resp_valid", resp_valid, 0);
      chk("beat_req_ready", req_ready, 0);
      if (!we) begin
        chk("rd_r_ena", vram_r_ena, 1);
        chk("rd_r_addr", vram_r_addr, a);
        chk("rd_w_ena", vram_w_ena, 0);
        exp_rd[k*DW +: DW] = mem_rd(a);
      end else begin
        chk("wr_r_ena", vram_r_ena, 0);
        chk("wr_w_ena", vram_w_ena, |b);
        chk("wr_w_addr", vram_w_addr, |b ? a : '0);
        chk("wr_w_mask", vram_w_mask, exp_mask(b));
        if (|b) chk("wr_w_data", vram_w_data, wd[k*DW +: DW]);
      end
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_we", resp_we, we);
      chk("resp_vd", resp_vd, vd);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_enables", {vram_r_ena, vram_w_ena}, 0);
      if (h < hold) begin
        resp_ready = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_resp_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0]   wd;
    logic [VLEN/8-1:0] bm;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", {resp_valid, resp_we, resp_vd}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_vram", {vram_r_ena, vram_w_ena, vram_r_addr, vram_w_addr, vram_w_data, vram_w_mask}, 0);
    rst = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    xfer(1'b0, 64'h1000, 64'h10, '0, '0, 5'd7, 0);
    wd = rnd_vec();
    xfer(1'b1, 64'h2000, 64'h40, wd, '1, 5'd3, 0);
    wd = rnd_vec();
    xfer(1'b1, 64'h4000, 64'h10, wd, 64'h0000_0000_FFFF_000F, 5'd9, 0);
    xfer(1'b0, 64'h5000, 64'h10, '0, '0, 5'd12, 3);
    xfer(1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, '0, '0, 5'd31, 0);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_base = 64'h3000; req_stride = 64'h10; req_vd = 5'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort_beat2_addr", vram_r_addr, 64'h3020);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_vram", {vram_r_ena, vram_r_addr, vram_w_ena}, 0);
    chk("abort_resp", {resp_valid, req_ready}, 0);
    chk("abort_rdata", resp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_rel_ready", req_ready, 1);
    repeat (BEATS + 2) begin
      @(posedge clk); #1;
      chk("abort_no_resp", resp_valid, 0);
    end
    xfer(1'b0, 64'h3000, 64'h10, '0, '0, 5'd6, 0);
    for (int t = 0; t < 8; t++) begin
      wd = rnd_vec();
      bm = rnd_vec()[VLEN/8-1:0];
      for (int k = 0; k < BEATS; k++) if ($urandom_range(0, 3) == 0) bm[k*BB +: BB] = '0;
      xfer(1'($urandom), {$urandom, $urandom}, ($urandom % 2) ? 64'h10 : {$urandom, $urandom},
           wd, bm, 5'($urandom), $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/v_lsu_burst.md
Name: v_lsu_burst

Overview:
Parametrised multi-beat vector load/store unit for the vector core. It replaces the single-beat vector memory path. One VLEN-wide vector access is split into BEATS = VLEN/VRAM_DW sequential VRAM beats. Supports unit-stride or beat-strided addressing and per-byte write masking. Sits between vector decode (request side) and write-back (response side), with valid/ready handshakes on both.

Parameters:
VLEN, 512, vector register width in bits; must be a multiple of VRAM_DW.
VRAM_DW, 128, VRAM data width per beat in bits; multiple of 8.
VRAM_AW, 64, VRAM byte-address width.
VREG_AW, 5, vector register tag width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid & ready
req_we  in  1  1 = store, 0 = load
req_base  in  VRAM_AW  byte address of beat 0
req_stride  in  VRAM_AW  byte distance between beats; unit stride = VRAM_DW/8
req_wdata  in  VLEN  store data; beat k = bits[k*VRAM_DW +: VRAM_DW]
req_bmask  in  VLEN/8  store byte enables; beat k = bits[k*VRAM_DW/8 +: VRAM_DW/8]
req_vd  in  VREG_AW  destination tag, echoed on response
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_we  out  1  echo of captured req_we
resp_vd  out  VREG_AW  echo of captured req_vd
resp_rdata  out  VLEN  assembled load data; 0 for stores
busy  out  1  state != IDLE
vram_r_ena  out  1  VRAM read enable
vram_r_addr  out  VRAM_AW  VRAM read address
vram_r_data  in  VRAM_DW  combinational read data, valid in the same cycle as the address
vram_w_ena  out  1  VRAM write enable; write commits at the clock edge
vram_w_addr  out  VRAM_AW  VRAM write address
vram_w_data  out  VRAM_DW  VRAM write data
vram_w_mask  out  VRAM_DW  bit mask; each byte-enable bit is replicated to 8 bits

Behaviour:
- States: IDLE, RD, WR, RESP. Beat counter cnt of width clog2(BEATS) (minimum 1 bit). Running address register addr.
- Reset (rst=0, async): state=IDLE, cnt=0, addr=0, all captured registers=0. Outputs: req_ready=1 once rst is released, all others 0. A reset during an operation abandons it; no response is produced and partial writes are not undone.
- IDLE:
  - req_ready=1.
  - On req_valid: capture base into addr, plus stride, wdata, bmask, vd and we; clear rdata buffer; cnt=0.
  - Next state is WR if we=1, otherwise RD.
- RD:
  - vram_r_ena=1, vram_r_addr=addr.
  - At the edge, rbuf[cnt*VRAM_DW +: VRAM_DW] <= vram_r_data, addr <= addr + stride (mod 2^VRAM_AW), cnt++.
  - When cnt==BEATS-1, go to RESP.
- WR:
  - vram_w_addr=addr, vram_w_data=wdata beat cnt, vram_w_mask=expanded bmask beat cnt.
  - vram_w_ena=1 only if that beat's byte mask is non-zero. An all-zero beat still consumes its cycle with w_ena=0.
  - addr/cnt update and exit to RESP are the same as RD.
- RESP:
  - resp_valid=1; resp_rdata/resp_vd/resp_we held stable.
  - On resp_ready, go to IDLE.
  - req_ready=0; req_valid is ignored.
- VRAM enables are 0 in IDLE and RESP. vram_r_addr and vram_w_addr are 0 whenever their enable is 0.
- Latency: accept at edge 0 → beats in cycles 1..BEATS → resp_valid in cycle BEATS+1. Minimum request period is BEATS+2 cycles.
- Address arithmetic wraps modulo 2^VRAM_AW. No alignment check; addresses are forwarded unmodified.
- BEATS==1 is legal: one RD/WR cycle, then RESP.

Test Plan:
(VLEN=512, VRAM_DW=128, BEATS=4)
1. Load, base 0x1000, stride 0x10 → r_addr 0x1000/0x1010/0x1020/0x1030 in cycles 1-4. resp_valid in cycle 5; resp_rdata[127:0]=beat-0 data … [511:384]=beat-3 data; resp_vd echoed.
2. Store, base 0x2000, stride 0x40, bmask all 1 → w_addr 0x2000/0x2040/0x2080/0x20C0. w_data = the matching wdata slices, w_mask all 1. Response has resp_we=1, resp_rdata=0.
3. Store with bmask=64'h0000_0000_FFFF_000F:
   - beat 0: w_mask=128'h0000…_FFFF_FFFF (low 32 bits set).
   - beat 1: w_mask all 1.
   - beats 2-3: w_ena=0, cycles still consumed.
   - resp_valid in cycle 5.
4. Backpressure: hold resp_ready=0 for 3 cycles in RESP → resp_valid/resp_rdata stable, req_ready=0, a concurrent req_valid is not accepted. Raising resp_ready → IDLE next cycle, req_ready=1.
5. Assert rst=0 mid-RD at beat 2 → outputs go to 0 immediately (asynchronously), no response follows. After release, req_ready=1 and a fresh load completes normally.
6. Wrap: base 0xFFFF_FFFF_FFFF_FFF0, stride 0x10 → r_addr 0x…FFF0, 0x0, 0x10, 0x20.
